// File: rtl/commutator_sched.sv
// Round-robin allocator of three commutator channels among five level requesters,
// with hold-time revocation of long-held channels when others are starved.
module commutator_sched #(
  parameter int N_SRC      = 5,
  parameter int N_CH       = 3,
  parameter int HOLD_LIMIT = 8,
  parameter int CNT_W      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] req,
  output logic [N_SRC-1:0] grant,
  output logic [2:0]       sel0,
  output logic [2:0]       sel1,
  output logic [2:0]       sel2,
  output logic [N_CH-1:0]  busy,
  output logic [N_SRC-1:0] revoked
);

  localparam logic [2:0]       IDLE  = 3'b111;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(HOLD_LIMIT);

  logic [N_SRC-1:0] grant_q, grant_d, revoked_q, revoked_d, pending;
  logic [N_CH-1:0]  busy_q, busy_d;
  logic [2:0]       rr_q, rr_d;
  logic [2:0]       sel_q [N_CH];
  logic [2:0]       sel_d [N_CH];
  logic [CNT_W-1:0] cnt_q [N_CH];
  logic [CNT_W-1:0] cnt_d [N_CH];

  logic       win_vld, free_vld, rv_vld;
  logic [2:0] win;
  logic [1:0] free_ch, rv_ch;

  function automatic logic [2:0] next_src(input logic [2:0] s);
    return (s == 3'(N_SRC - 1)) ? 3'd0 : s + 3'd1;
  endfunction

  assign pending = req & ~grant_q;

  // Descending scans so the last hit is the first in search order.
  always_comb begin
    int k;
    win_vld  = 1'b0;
    win      = '0;
    free_vld = 1'b0;
    free_ch  = '0;
    rv_vld   = 1'b0;
    rv_ch    = '0;
    for (int j = N_SRC - 1; j >= 0; j--) begin
      k = (int'(rr_q) + j) % N_SRC;
      if (pending[k]) begin
        win_vld = 1'b1;
        win     = 3'(k);
      end
    end
    for (int c = N_CH - 1; c >= 0; c--) begin
      if (!busy_q[c]) begin
        free_vld = 1'b1;
        free_ch  = 2'(c);
      end
      if (busy_q[c] && cnt_q[c] == LIMIT) begin
        rv_vld = 1'b1;
        rv_ch  = 2'(c);
      end
    end
  end

  always_comb begin
    grant_d   = grant_q;
    busy_d    = busy_q;
    rr_d      = rr_q;
    revoked_d = '0;
    sel_d     = sel_q;
    cnt_d     = cnt_q;

    for (int c = 0; c < N_CH; c++) begin
      if (busy_q[c] && cnt_q[c] != LIMIT) cnt_d[c] = cnt_q[c] + 1'b1;
      if (busy_q[c] && !req[sel_q[c]]) begin
        busy_d[c]           = 1'b0;
        sel_d[c]            = IDLE;
        grant_d[sel_q[c]]   = 1'b0;
        cnt_d[c]            = '0;
      end
    end

    if (pending != '0 && free_vld && win_vld) begin
      busy_d[free_ch] = 1'b1;
      sel_d[free_ch]  = win;
      grant_d[win]    = 1'b1;
      cnt_d[free_ch]  = '0;
      rr_d            = next_src(win);
    end else if (HOLD_LIMIT != 0 && (&busy_q) && pending != '0 && rv_vld
                 && req[sel_q[rv_ch]]) begin
      // A channel whose owner is releasing this edge is simply released, not revoked.
      busy_d[rv_ch]            = 1'b0;
      sel_d[rv_ch]             = IDLE;
      grant_d[sel_q[rv_ch]]    = 1'b0;
      revoked_d[sel_q[rv_ch]]  = 1'b1;
      cnt_d[rv_ch]             = '0;
      rr_d                     = next_src(sel_q[rv_ch]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_q   <= '0;
      busy_q    <= '0;
      revoked_q <= '0;
      rr_q      <= '0;
      for (int c = 0; c < N_CH; c++) begin
        sel_q[c] <= IDLE;
        cnt_q[c] <= '0;
      end
    end else begin
      grant_q   <= grant_d;
      busy_q    <= busy_d;
      revoked_q <= revoked_d;
      rr_q      <= rr_d;
      sel_q     <= sel_d;
      cnt_q     <= cnt_d;
    end
  end

  assign grant   = grant_q;
  assign busy    = busy_q;
  assign revoked = revoked_q;
  assign sel0    = sel_q[0];
  assign sel1    = sel_q[1];
  assign sel2    = sel_q[2];

endmodule

// File: tb/tb_commutator_sched.sv
// Bench for commutator_sched: two instances (hold limit 8 and 0) against a channel-ownership model.
module tb_commutator_sched;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [4:0] req = '0;

  logic [1:0][4:0] g, rv;
  logic [1:0][2:0] s0, s1, s2, b;

  commutator_sched #(.HOLD_LIMIT(8)) dut_a (
    .clk(clk), .rst(rst), .req(req), .grant(g[0]), .sel0(s0[0]), .sel1(s1[0]),
    .sel2(s2[0]), .busy(b[0]), .revoked(rv[0]));

  commutator_sched #(.HOLD_LIMIT(0)) dut_b (
    .clk(clk), .rst(rst), .req(req), .grant(g[1]), .sel0(s0[1]), .sel1(s1[1]),
    .sel2(s2[1]), .busy(b[1]), .revoked(rv[1]));

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Model: owner source per channel (-1 idle), hold age, search pointer.
  int own  [2][3];
  int hold [2][3];
  int rr   [2];
  logic [4:0] mg [2];
  logic [4:0] mrev [2];
  int lim [2] = '{8, 0};

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int c = 0; c < 3; c++) begin
        own[k][c]  = -1;
        hold[k][c] = 0;
      end
      rr[k] = 0; mg[k] = '0; mrev[k] = '0;
    end
  endtask

  task automatic model_step(input int k, input logic [4:0] r);
    int nown[3];
    int nhold[3];
    logic [4:0] ng, pend;
    bit full;
    int s, c;
    pend = r & ~mg[k];
    full = (own[k][0] >= 0) && (own[k][1] >= 0) && (own[k][2] >= 0);
    ng = mg[k];
    mrev[k] = '0;
    for (int i = 0; i < 3; i++) begin
      nown[i]  = own[k][i];
      nhold[i] = (own[k][i] >= 0) ? ((hold[k][i] + 1 > lim[k]) ? lim[k] : hold[k][i] + 1) : 0;
      if (own[k][i] >= 0 && !r[own[k][i]]) begin
        nown[i] = -1; nhold[i] = 0; ng[own[k][i]] = 1'b0;
      end
    end
    if (pend != 0 && !full) begin
      s = -1;
      for (int j = 0; j < 5; j++)
        if (s < 0 && pend[(rr[k] + j) % 5]) s = (rr[k] + j) % 5;
      c = -1;
      for (int i = 0; i < 3; i++)
        if (c < 0 && own[k][i] < 0) c = i;
      nown[c] = s; nhold[c] = 0; ng[s] = 1'b1; rr[k] = (s + 1) % 5;
    end else if (lim[k] != 0 && full && pend != 0) begin
      c = -1;
      for (int i = 0; i < 3; i++)
        if (c < 0 && hold[k][i] == lim[k]) c = i;
      if (c >= 0 && r[own[k][c]]) begin
        s = own[k][c];
        nown[c] = -1; nhold[c] = 0; ng[s] = 1'b0; mrev[k][s] = 1'b1; rr[k] = (s + 1) % 5;
      end
    end
    for (int i = 0; i < 3; i++) begin
      own[k][i] = nown[i]; hold[k][i] = nhold[i];
    end
    mg[k] = ng;
  endtask

  function automatic int exp_sel(input int k, input int c);
    return (own[k][c] < 0) ? 7 : own[k][c];
  endfunction

  task automatic check_all();
    logic [2:0] eb;
    logic dup;
    for (int k = 0; k < 2; k++) begin
      for (int c = 0; c < 3; c++) eb[c] = (own[k][c] >= 0);
      check($sformatf("grant[%0d]", k), g[k], mg[k]);
      check($sformatf("sel0[%0d]", k), s0[k], exp_sel(k, 0));
      check($sformatf("sel1[%0d]", k), s1[k], exp_sel(k, 1));
      check($sformatf("sel2[%0d]", k), s2[k], exp_sel(k, 2));
      check($sformatf("busy[%0d]", k), b[k], eb);
      check($sformatf("revoked[%0d]", k), rv[k], mrev[k]);
      check($sformatf("popcount[%0d]", k), $countones(g[k]), $countones(b[k]));
      dup = (s0[k] != 7 && (s0[k] == s1[k] || s0[k] == s2[k])) || (s1[k] != 7 && s1[k] == s2[k]);
      check($sformatf("dup_sel[%0d]", k), dup, 0);
    end
  endtask

  task automatic tick();
    model_step(0, req);
    model_step(1, req);
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    model_reset();
    #12;
    check("rst_grant", g[0], 0);
    check("rst_sel0", s0[0], 7);
    check("rst_busy", b[0], 0);
    check("rst_revoked", rv[0], 0);
    @(negedge clk);
    rst = 1'b0;

    req = 5'b00111;
    tick(); check("s1_grant1", g[0], 5'b00001); check("s1_sel0", s0[0], 0);
    tick(); check("s1_grant2", g[0], 5'b00011); check("s1_sel1", s1[0], 1);
    tick(); check("s1_grant3", g[0], 5'b00111); check("s1_busy", b[0], 3'b111);
    check("s1_sel2", s2[0], 2);

    req = 5'b10101;
    tick(); check("s2_grant", g[0], 5'b00101); check("s2_busy", b[0], 3'b101);
    check("s2_sel1_idle", s1[0], 7);
    tick(); check("s2_sel1_src4", s1[0], 4); check("s2_grant4", g[0], 5'b10101);

    do_reset();
    req = 5'b11111;
    tick(); check("rr_grant1", g[0], 5'b00001);
    tick(); check("rr_grant2", g[0], 5'b00011);
    tick(); check("rr_grant3", g[0], 5'b00111);
    repeat (6) tick();
    check("starve_no_rev_yet", rv[0], 0);
    tick();
    check("starve_revoked", rv[0], 5'b00001);
    check("starve_grant", g[0], 5'b00110);
    check("nolimit_revoked", rv[1], 0);
    tick();
    check("starve_sel0_src3", s0[0], 3);
    check("starve_pulse_end", rv[0], 0);
    repeat (39) tick();
    check("nolimit_grant", g[1], 5'b00111);
    check("nolimit_sel0", s0[1], 0);

    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_busy_a", b[0], 0);
    check("async_busy_b", b[1], 0);
    check("async_grant_b", g[1], 0);
    check("async_sel2_b", s2[1], 7);
    @(posedge clk);
    #1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    tick();
    check("restart_grant_a", g[0], 5'b00001);
    check("restart_grant_b", g[1], 5'b00001);

    repeat (600) begin
      for (int i = 0; i < 5; i++)
        if ($urandom_range(11) == 0) req[i] = ~req[i];
      if ($urandom_range(149) == 0) do_reset();
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
